bf16_matmul_sequencer: RTL and testbench



---
 rtl/bf16_matmul_sequencer_if.sv | 27 ++
 rtl/bf16_matmul_sequencer.sv | 139 +++++++++++++
 tb/tb_bf16_matmul_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/bf16_matmul_sequencer_if.sv
// Job handshake and PE-array control strobes between a host and the bf16 matmul sequencer.
// The master side requests jobs; the slave side (the sequencer) drives the control strobes.
interface bf16_matmul_sequencer_if #(
  parameter int KW = 1
);
  logic          start_valid;
  logic          start_ready;
  logic          abort;
  logic          acc_clear;
  logic          issue;
  logic [KW-1:0] k_idx;
  logic          acc_en;
  logic          acc_wr;
  logic          capture;
  logic          done;
  logic          busy;

  modport master (
    output start_valid, abort,
    input  start_ready, acc_clear, issue, k_idx, acc_en, acc_wr, capture, done, busy
  );

  modport slave (
    input  start_valid, abort,
    output start_ready, acc_clear, issue, k_idx, acc_en, acc_wr, capture, done, busy
  );
endinterface

// File: rtl/bf16_matmul_sequencer.sv
// Control sequencer for a SIZE x SIZE bfloat16 PE array: clear, paced k-step issue, drain, capture.
// acc_en/acc_wr are issue delayed through the multiplier and multiplier+adder pipeline depths.
module bf16_matmul_sequencer #(
  parameter int SIZE     = 2,
  parameter int MULT_LAT = 3,
  parameter int ADD_LAT  = 3,
  parameter int KW       = (SIZE > 2) ? $clog2(SIZE) : 1
) (
  input logic                    clk,
  input logic                    rst,
  bf16_matmul_sequencer_if.slave bus
);

  localparam int WR_LAT  = MULT_LAT + ADD_LAT;
  localparam int GAP_W   = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam int DRAIN_W = $clog2(WR_LAT);
  localparam logic [KW-1:0]      K_LAST     = KW'(SIZE - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(ADD_LAT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(WR_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_GAP, S_DRAIN, S_CAPTURE, S_DONE
  } state_t;

  state_t              state;
  logic [KW-1:0]       k_q;
  logic [GAP_W-1:0]    gap_cnt;
  logic [DRAIN_W-1:0]  drain_cnt;
  logic                acc_clear_q, issue_q, capture_q, done_q, busy_q;
  logic [MULT_LAT-1:0] en_line;
  logic [WR_LAT-1:0]   wr_line;
  logic                start_ready_w;

  assign start_ready_w = (state == S_IDLE) && !bus.abort;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      k_q         <= '0;
      gap_cnt     <= '0;
      drain_cnt   <= '0;
      acc_clear_q <= 1'b0;
      issue_q     <= 1'b0;
      capture_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      en_line     <= '0;
      wr_line     <= '0;
    end else if (bus.abort && state != S_IDLE) begin
      // Flushing the delay lines keeps an aborted step from writing the partial sums.
      state       <= S_IDLE;
      k_q         <= '0;
      gap_cnt     <= '0;
      drain_cnt   <= '0;
      acc_clear_q <= 1'b0;
      issue_q     <= 1'b0;
      capture_q   <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      en_line     <= '0;
      wr_line     <= '0;
    end else begin
      acc_clear_q <= 1'b0;
      issue_q     <= 1'b0;
      capture_q   <= 1'b0;
      done_q      <= 1'b0;
      en_line[0]  <= issue_q;
      wr_line[0]  <= issue_q;
      for (int i = 1; i < MULT_LAT; i++) en_line[i] <= en_line[i-1];
      for (int i = 1; i < WR_LAT; i++)   wr_line[i] <= wr_line[i-1];

      case (state)
        S_IDLE: begin
          if (bus.start_valid && start_ready_w) begin
            state       <= S_CLEAR;
            acc_clear_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        S_CLEAR: begin
          state   <= S_ISSUE;
          issue_q <= 1'b1;
          k_q     <= '0;
        end
        S_ISSUE: begin
          if (k_q == K_LAST) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end
        S_GAP: begin
          // ADD_LAT idle cycles give STEP = ADD_LAT+1 between issues.
          if (gap_cnt == GAP_LAST) begin
            state   <= S_ISSUE;
            issue_q <= 1'b1;
            k_q     <= k_q + KW'(1);
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state     <= S_CAPTURE;
            capture_q <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DRAIN_W'(1);
          end
        end
        S_CAPTURE: begin
          state  <= S_DONE;
          done_q <= 1'b1;
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_w;
  assign bus.acc_clear   = acc_clear_q;
  assign bus.issue       = issue_q;
  assign bus.k_idx       = k_q;
  assign bus.acc_en      = en_line[MULT_LAT-1];
  assign bus.acc_wr      = wr_line[WR_LAT-1];
  assign bus.capture     = capture_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bf16_matmul_sequencer.sv
// Bench for bf16_matmul_sequencer: two configurations share stimulus and are checked every cycle
// against a timeline model; directed runs also pin pulse positions with hand-computed masks.
module tb_bf16_matmul_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sv  = 1'b0;
  logic ab  = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bf16_matmul_sequencer_if #(.KW(1)) bus0 ();
  bf16_matmul_sequencer_if #(.KW(2)) bus4 ();

  assign bus0.start_valid = sv;
  assign bus0.abort       = ab;
  assign bus4.start_valid = sv;
  assign bus4.abort       = ab;

  bf16_matmul_sequencer #(.SIZE(2), .MULT_LAT(3), .ADD_LAT(3), .KW(1)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  bf16_matmul_sequencer #(.SIZE(4), .MULT_LAT(2), .ADD_LAT(1), .KW(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  typedef struct packed {
    logic       clr, iss, en, wr, cap, dn, busy, rdy;
    logic [1:0] k;
  } obs_t;

  typedef struct packed {
    logic [31:0] clr, iss, en, wr, cap, dn, busy, rdy;
  } mask_t;

  obs_t  obs [2];
  mask_t mk  [2];

  assign obs[0] = {bus0.acc_clear, bus0.issue, bus0.acc_en, bus0.acc_wr, bus0.capture,
                   bus0.done, bus0.busy, bus0.start_ready, 1'b0, bus0.k_idx};
  assign obs[1] = {bus4.acc_clear, bus4.issue, bus4.acc_en, bus4.acc_wr, bus4.capture,
                   bus4.done, bus4.busy, bus4.start_ready, bus4.k_idx};

  task automatic check(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s dut%0d cyc %0d: got 0x%0h expected 0x%0h", name, d, cyc, got, want);
  endtask

  function automatic int p_s(input int d); return (d == 0) ? 2 : 4; endfunction
  function automatic int p_m(input int d); return (d == 0) ? 3 : 2; endfunction
  function automatic int p_a(input int d); return (d == 0) ? 3 : 1; endfunction

  function automatic int cap_of(input int d);
    return 3 + (p_s(d) - 1) * (p_a(d) + 1) + p_m(d) + p_a(d);
  endfunction

  // Expected outputs rel cycles after the accept cycle of the live job.
  function automatic obs_t model(input int d, input bit act, input int rel, input bit abort_in);
    obs_t e;
    int   step;
    int   t;
    e    = '0;
    step = p_a(d) + 1;
    if (!act) begin
      e.rdy = !abort_in;
      return e;
    end
    e.clr = (rel == 1);
    for (int k = 0; k < p_s(d); k++) begin
      t = 2 + k * step;
      if (rel == t) begin
        e.iss = 1'b1;
        e.k   = 2'(k);
      end
      if (rel == t + p_m(d)) e.en = 1'b1;
      if (rel == t + p_m(d) + p_a(d)) e.wr = 1'b1;
    end
    e.cap  = (rel == cap_of(d));
    e.dn   = (rel == cap_of(d) + 1);
    e.busy = (rel >= 1);
    return e;
  endfunction

  bit act [2];
  int a0  [2];

  always begin
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      int   rel;
      obs_t e;
      if (rst) act[d] = 1'b0;
      rel = cyc - a0[d];
      if (act[d] && rel > cap_of(d) + 1) act[d] = 1'b0;
      e = model(d, act[d], rel, ab);
      check("acc_clear",   d, 32'(obs[d].clr),  32'(e.clr));
      check("issue",       d, 32'(obs[d].iss),  32'(e.iss));
      check("acc_en",      d, 32'(obs[d].en),   32'(e.en));
      check("acc_wr",      d, 32'(obs[d].wr),   32'(e.wr));
      check("capture",     d, 32'(obs[d].cap),  32'(e.cap));
      check("done",        d, 32'(obs[d].dn),   32'(e.dn));
      check("busy",        d, 32'(obs[d].busy), 32'(e.busy));
      check("start_ready", d, 32'(obs[d].rdy),  32'(e.rdy));
      if (e.iss) check("k_idx", d, 32'(obs[d].k), 32'(e.k));
      if (act[d] && ab) act[d] = 1'b0;
      else if (!act[d] && sv && !ab && !rst) begin
        act[d] = 1'b1;
        a0[d]  = cyc;
      end
    end
  end

  // Drives n cycles relative to r=0 and records per-cycle pulse positions into mk.
  task automatic run(input int n, input int sv_len, input int ab_lo, input int ab_hi, input int rst_at);
    for (int d = 0; d < 2; d++) mk[d] = '0;
    for (int r = 0; r < n; r++) begin
      @(negedge clk);
      sv  = (r < sv_len);
      ab  = (r >= ab_lo) && (r <= ab_hi);
      rst = (r == rst_at);
      #2;
      if (r < 32) begin
        for (int d = 0; d < 2; d++) begin
          mk[d].clr  |= 32'(obs[d].clr)  << r;
          mk[d].iss  |= 32'(obs[d].iss)  << r;
          mk[d].en   |= 32'(obs[d].en)   << r;
          mk[d].wr   |= 32'(obs[d].wr)   << r;
          mk[d].cap  |= 32'(obs[d].cap)  << r;
          mk[d].dn   |= 32'(obs[d].dn)   << r;
          mk[d].busy |= 32'(obs[d].busy) << r;
          mk[d].rdy  |= 32'(obs[d].rdy)  << r;
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    check("rst_start_ready", 0, 32'(bus0.start_ready), 32'd1);
    check("rst_busy",        0, 32'(bus0.busy),        32'd0);
    check("rst_k_idx",       0, 32'(bus0.k_idx),       32'd0);
    check("rst_acc_wr",      1, 32'(bus4.acc_wr),      32'd0);

    run(2, 0, -1, -1, -1);

    // Single job with default and SIZE=4 configurations.
    run(18, 1, -1, -1, -1);
    check("single_clr",  0, mk[0].clr,  32'h0000_0002);
    check("single_iss",  0, mk[0].iss,  32'h0000_0044);
    check("single_en",   0, mk[0].en,   32'h0000_0220);
    check("single_wr",   0, mk[0].wr,   32'h0000_1100);
    check("single_cap",  0, mk[0].cap,  32'h0000_2000);
    check("single_done", 0, mk[0].dn,   32'h0000_4000);
    check("single_busy", 0, mk[0].busy, 32'h0000_7FFE);
    check("single_rdy",  0, mk[0].rdy,  32'h0003_8001);
    check("s4_iss",      1, mk[1].iss,  32'h0000_0154);
    check("s4_en",       1, mk[1].en,   32'h0000_0550);
    check("s4_wr",       1, mk[1].wr,   32'h0000_0AA0);
    check("s4_cap",      1, mk[1].cap,  32'h0000_1000);
    check("s4_done",     1, mk[1].dn,   32'h0000_2000);

    // Back-to-back jobs with start_valid held.
    run(40, 40, -1, -1, -1);
    check("b2b_iss",     0, mk[0].iss,  32'h0022_0044);
    check("b2b_wr",      0, mk[0].wr,   32'h0880_1100);
    check("b2b_done",    0, mk[0].dn,   32'h2000_4000);
    check("b2b_overlap", 0, mk[0].iss & mk[0].wr, 32'h0);
    run(20, 0, -1, -1, -1);

    // Abort during cycle 7 of a job.
    run(12, 1, 7, 7, -1);
    check("abort_en",   0, mk[0].en,   32'h0000_0020);
    check("abort_wr",   0, mk[0].wr,   32'h0);
    check("abort_cap",  0, mk[0].cap,  32'h0);
    check("abort_done", 0, mk[0].dn,   32'h0);
    check("abort_busy", 0, mk[0].busy, 32'h0000_00FE);
    check("abort_rdy",  0, mk[0].rdy,  32'h0000_0F01);

    // Asynchronous reset pulse during cycle 10 of a job.
    run(32, 1, -1, -1, 10);
    check("rst_iss",   0, mk[0].iss,  32'h0000_0044);
    check("rst_wr",    0, mk[0].wr,   32'h0000_0100);
    check("rst_busy",  0, mk[0].busy, 32'h0000_03FE);
    check("rst_rdy",   0, mk[0].rdy,  32'hFFFF_FC01);
    check("rst_quiet", 0, (mk[0].clr | mk[0].iss | mk[0].en | mk[0].wr | mk[0].cap | mk[0].dn) >> 10, 32'h0);
    check("rst_quiet", 1, (mk[1].clr | mk[1].iss | mk[1].en | mk[1].wr | mk[1].cap | mk[1].dn | mk[1].busy) >> 10, 32'h0);

    // start_valid while abort is high in IDLE.
    run(8, 8, 0, 2, -1);
    check("idle_abort_busy", 0, mk[0].busy, 32'h0000_00F0);
    check("idle_abort_clr",  0, mk[0].clr,  32'h0000_0010);
    check("idle_abort_rdy",  0, mk[0].rdy,  32'h0000_0008);
    run(20, 0, -1, -1, -1);

    // Randomized start/abort traffic checked by the model every cycle.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      sv = ($urandom_range(0, 3) != 0);
      ab = ($urandom_range(0, 24) == 0);
    end
    run(25, 0, -1, -1, -1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
